// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter: default geometry, op codes and the
// pipeline stage record carried from issue to write commit.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 11;
  localparam int unsigned SRAM_DATA_W = 128;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  typedef struct packed {
    op_e                    op;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/sram_op_pipe.sv
// Two-stage op/addr/data shift register aligning write data with the macro's
// WEN/D sampling edge. Both stages clear asynchronously, dropping in-flight ops.
module sram_op_pipe
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  stage_t issue_i,
  output stage_t s1_o,
  output stage_t s2_o
);

  stage_t s1_q, s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= issue_i;
      s2_q <= s1_q;
    end
  end

  assign s1_o = s1_q;
  assign s2_o = s2_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one single-port SRAM between a write and a read requester, one access
// per cycle, with read-after-write protection (stall, or forward with SRAM_ARB_FWD_EN).
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  // Handshake: a requester holds req and its address/data stable; the access
  // happens in the cycle where req && gnt, and gnt is combinational in that cycle.

  stage_t            issue, s1, s2;
  logic              rr_last_wr_q, rr_last_wr_d;
  logic [ADDR_W-1:0] a_hold_q;
  logic              rd_valid_q;
  logic              raw_hit, rd_elig, wr_win, rd_win;

  // A write sitting in S1 has not committed when a read issued now samples the array.
  assign raw_hit = rd_req && (s1.op == OP_WR) && (s1.addr == rd_addr);

`ifdef SRAM_ARB_FWD_EN
  logic fwd_q;
  assign rd_elig = rd_req;
`else
  assign rd_elig = rd_req && !raw_hit;
`endif

  always_comb begin
    wr_win       = 1'b0;
    rd_win       = 1'b0;
    issue        = '0;
    rr_last_wr_d = rr_last_wr_q;
    if (reset_n) begin
      if (wr_req && rd_elig) begin
        if (rr_last_wr_q) rd_win = 1'b1;
        else              wr_win = 1'b1;
      end else if (wr_req) begin
        wr_win = 1'b1;
      end else if (rd_elig) begin
        rd_win = 1'b1;
      end
    end
    if (wr_win) begin
      issue.op     = OP_WR;
      issue.addr   = wr_addr;
      issue.data   = wr_data;
      rr_last_wr_d = 1'b1;
    end else if (rd_win) begin
      issue.op     = OP_RD;
      issue.addr   = rd_addr;
      rr_last_wr_d = 1'b0;
    end
  end

  sram_op_pipe u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .issue_i (issue),
    .s1_o    (s1),
    .s2_o    (s2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_wr_q <= 1'b0;
      a_hold_q     <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      rr_last_wr_q <= rr_last_wr_d;
      rd_valid_q   <= rd_win;
      if (wr_win || rd_win) a_hold_q <= issue.addr;
    end
  end

`ifdef SRAM_ARB_FWD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fwd_q <= 1'b0;
    else          fwd_q <= rd_win && raw_hit;
  end
  // The forwarded write has moved into S2 by the time its read returns.
  assign rd_data = !rd_valid_q ? '0 : (fwd_q ? s2.data : sram_q);
`else
  assign rd_data = rd_valid_q ? sram_q : '0;
`endif

  assign wr_gnt   = wr_win;
  assign rd_gnt   = rd_win;
  assign rd_valid = rd_valid_q;
  assign sram_cen = !(wr_win || rd_win);
  assign sram_ren = rd_win;
  assign sram_a   = (wr_win || rd_win) ? issue.addr : a_hold_q;
  assign sram_wen = (s2.op == OP_WR);
  assign sram_d   = s2.data;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a behavioural SRAM macro model,
// a read-data scoreboard and a write-commit timing monitor.
module tb_sram_access_arbiter;

  localparam int AW = 11;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_cen, sram_wen, sram_ren;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  always #5 clk = ~clk;

  sram_access_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .sram_cen (sram_cen),
    .sram_wen (sram_wen),
    .sram_ren (sram_ren),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return {4{32'hC0DE0000 | i}};
  endfunction

  // SRAM macro: address latched on the issue edge, WEN/D sampled two edges later
  // (write-first on that edge), Q valid in the following cycle.
  logic [DW-1:0] sram_mem [0:2047];
  logic [AW-1:0] lat_a0 = '0, lat_a1 = '0;
  bit            model_ready = 1'b0;

  always @(posedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 2048; i++) sram_mem[i] = init_word(i);
      model_ready = 1'b1;
    end
    if (sram_wen) sram_mem[lat_a1] = sram_d;
    if (!sram_cen && sram_ren) sram_q <= sram_mem[sram_a];
    lat_a1 = lat_a0;
    lat_a0 = sram_a;
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:2047];
  logic          cen_s;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: read data against the scoreboard, write commit timing against grants.
  logic          wg_h1 = 1'b0, wg_h2 = 1'b0, rg_h1 = 1'b0;
  logic [DW-1:0] wd_h1 = '0, wd_h2 = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      wg_h1 = 1'b0; wg_h2 = 1'b0; rg_h1 = 1'b0;
      wd_h1 = '0;   wd_h2 = '0;
    end else begin
      check("sram_wen_timing", DW'(sram_wen), DW'(wg_h2));
      if (wg_h2) check("sram_d", sram_d, wd_h2);
      if (rd_valid || rg_h1) check("rd_valid_timing", DW'(rd_valid), DW'(rg_h1));
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_unexpected", DW'(1), DW'(0));
        else                   check("rd_data", rd_data, exp_q.pop_front());
      end
      wg_h2 = wg_h1; wg_h1 = wr_gnt; wd_h2 = wd_h1; wd_h1 = wr_data;
      rg_h1 = rd_gnt;
    end
  end

  // One cycle of stimulus: drive just after posedge, sample grants at negedge.
  task automatic cycle(input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rq, input logic [AW-1:0] ra,
                       output logic wg, output logic rg);
    wr_req = wq; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = ra;
    @(negedge clk);
    wg    = wr_gnt;
    rg    = rd_gnt;
    cen_s = sram_cen;
    if (wg) ref_mem[wa] = wd;
    if (rg) exp_q.push_back(ref_mem[ra]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic wg, rg;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0, wg, rg);
      check("idle_no_gnt", DW'({wg, rg}), DW'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cen"},   DW'(sram_cen), DW'(1));
    check({tag, "_wen"},   DW'(sram_wen), DW'(0));
    check({tag, "_ren"},   DW'(sram_ren), DW'(0));
    check({tag, "_a"},     DW'(sram_a),   DW'(0));
    check({tag, "_d"},     sram_d,        '0);
    check({tag, "_valid"}, DW'(rd_valid), DW'(0));
    check({tag, "_rdata"}, rd_data,       '0);
    check({tag, "_gnt"},   DW'({wr_gnt, rd_gnt}), DW'(0));
  endtask

  initial begin
    logic          wg, rg;
    int            cnt;
    logic [DW-1:0] old3;

    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);

    // Requests held high through reset must not be granted.
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 11'd9; rd_addr = 11'd4;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    reset_n = 1'b1;

    // Contention: strict alternation starting with the writer, no idle slot.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 11'd10, DW'(100 + i), 1'b1, 11'd20, wg, rg);
      check("contend_wr_gnt", DW'(wg), DW'((i % 2) == 0));
      check("contend_rd_gnt", DW'(rg), DW'((i % 2) == 1));
      check("contend_cen", DW'(cen_s), DW'(0));
    end
    idle(2);

    // Single write then read of the same address.
    cycle(1'b1, 11'd5, {16{8'hA5}}, 1'b0, '0, wg, rg);
    check("single_wr_gnt", DW'(wg), DW'(1));
    idle(3);
    cycle(1'b0, '0, '0, 1'b1, 11'd5, wg, rg);
    check("single_rd_gnt", DW'(rg), DW'(1));
    idle(2);

    // Read-after-write on the address still in S1.
    cycle(1'b1, 11'd7, DW'(32'h1234), 1'b0, '0, wg, rg);
    check("raw_wr_gnt", DW'(wg), DW'(1));
    cycle(1'b0, '0, '0, 1'b1, 11'd7, wg, rg);
`ifdef SRAM_ARB_FWD_EN
    check("raw_fwd_rd_gnt", DW'(rg), DW'(1));
`else
    check("raw_stall_rd_gnt", DW'(rg), DW'(0));
    check("raw_stall_cen", DW'(cen_s), DW'(1));
    cycle(1'b0, '0, '0, 1'b1, 11'd7, wg, rg);
    check("raw_retry_rd_gnt", DW'(rg), DW'(1));
`endif
    idle(2);

    // Neighbouring address is not a hazard.
    cycle(1'b1, 11'd7, DW'(32'h5555), 1'b0, '0, wg, rg);
    check("nc_wr_gnt", DW'(wg), DW'(1));
    cycle(1'b0, '0, '0, 1'b1, 11'd8, wg, rg);
    check("nc_rd_gnt", DW'(rg), DW'(1));
    idle(2);

    // Streaming: 64 writes then 64 reads, one op per cycle.
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, AW'(i), DW'(i), 1'b0, '0, wg, rg);
      if (wg) cnt++;
    end
    check("stream_wr_count", DW'(cnt), DW'(64));
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, '0, '0, 1'b1, AW'(i), wg, rg);
      if (rg) cnt++;
    end
    check("stream_rd_count", DW'(cnt), DW'(64));
    idle(3);

    // Reset with a write in flight: the write is dropped.
    old3 = ref_mem[3];
    cycle(1'b1, 11'd3, DW'(32'hBEEF), 1'b0, '0, wg, rg);
    check("rstw_wr_gnt", DW'(wg), DW'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    ref_mem[3] = old3;
    @(negedge clk);
    check("midreset_wen_n1", DW'(sram_wen), DW'(0));
    @(negedge clk);
    check("midreset_wen_n2", DW'(sram_wen), DW'(0));
    @(posedge clk);
    wr_req = 1'b0;
    #1;
    reset_n = 1'b1;
    idle(2);
    cycle(1'b0, '0, '0, 1'b1, 11'd3, wg, rg);
    check("rstw_rd_gnt", DW'(rg), DW'(1));
    idle(2);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 10) begin
      @(posedge clk);
      cnt++;
    end
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
